// File: rtl/mc_control_unit_pkg.sv
// mc_control_unit_pkg: shared definitions for the multicycle control unit.
//   ctrl_state_e       FSM state encoding (fixed values for legacy traces)
//   ALU_*              ALUOp function codes
//   SPLICE_*           access-size codes for LoadSplice/StoreSplice
//   OP_*, F3_*, F7_*   RV64 opcode / funct3 / funct7 field values
//   load_splice/store_splice  funct3 -> access-size helpers
package mc_control_unit_pkg;

  typedef enum logic [4:0] {
    FETCH     = 5'd0,
    IR_LOAD   = 5'd1,
    DECODE    = 5'd2,
    EXEC_R    = 5'd3,
    EXEC_I    = 5'd4,
    ALU_WB    = 5'd5,
    MEM_ADDR  = 5'd6,
    MEM_RD    = 5'd7,
    MEM_LATCH = 5'd8,
    LOAD_WB   = 5'd9,
    MEM_WR    = 5'd10,
    BR_CMP    = 5'd11,
    BR_TGT    = 5'd12,
    JAL       = 5'd13,
    JALR      = 5'd14,
    LUI       = 5'd15,
    EXCEPT    = 5'd16,
    HALT      = 5'd17
  } ctrl_state_e;

  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;

  localparam logic [1:0] SPLICE_D = 2'b00;
  localparam logic [1:0] SPLICE_W = 2'b01;
  localparam logic [1:0] SPLICE_H = 2'b10;
  localparam logic [1:0] SPLICE_B = 2'b11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  function automatic logic [1:0] load_splice(input logic [2:0] f3);
    case (f3)
      F3_D:    return SPLICE_D;
      F3_W:    return SPLICE_W;
      F3_H:    return SPLICE_H;
      default: return SPLICE_B;
    endcase
  endfunction

  function automatic logic [1:0] store_splice(input logic [2:0] f3);
    case (f3)
      F3_D:    return SPLICE_D;
      F3_W:    return SPLICE_W;
      F3_H:    return SPLICE_H;
      default: return SPLICE_B;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: control-unit <-> datapath bundle.
//   master: control unit (consumes instruction + ALU flags, drives all flags)
//   slave : datapath side (drives instruction + ALU flags, consumes flags)
interface mc_control_unit_if;
  logic [31:0] instruction;
  logic        alu_zero, alu_equal, alu_greater, alu_less;
  logic        PCWriteState, PCSource;
  logic [1:0]  ALUSrcA, ALUSrcB;
  logic [3:0]  ALUOp;
  logic        LoadAOut, LoadRegA, LoadRegB, RegWrite, LoadMDR;
  logic [1:0]  MemToReg;
  logic        DMemOp;
  logic [1:0]  LoadSplice, StoreSplice;
  logic        IMemRead, IRWrite;
  logic        IntCause, EPCWrite, CauseWrite;
  logic        halted;

  modport master (
    input  instruction, alu_zero, alu_equal, alu_greater, alu_less,
    output PCWriteState, PCSource, ALUSrcA, ALUSrcB, ALUOp,
           LoadAOut, LoadRegA, LoadRegB, RegWrite, LoadMDR, MemToReg,
           DMemOp, LoadSplice, StoreSplice, IMemRead, IRWrite,
           IntCause, EPCWrite, CauseWrite, halted
  );

  modport slave (
    output instruction, alu_zero, alu_equal, alu_greater, alu_less,
    input  PCWriteState, PCSource, ALUSrcA, ALUSrcB, ALUOp,
           LoadAOut, LoadRegA, LoadRegB, RegWrite, LoadMDR, MemToReg,
           DMemOp, LoadSplice, StoreSplice, IMemRead, IRWrite,
           IntCause, EPCWrite, CauseWrite, halted
  );
endinterface

// File: rtl/mc_control_unit_ctrl_alu_decode.sv
// ctrl_alu_decode: combinational instruction-field decode.
//   opcode, funct3, funct7 -> alu_op (ALUOp for EXEC_R/EXEC_I), legal
// legal covers R-type op combos, load/store funct3 and branch funct3.
// Macro CTRL_BRANCH_EXT_EN: also accept blt/bge branch funct3.
module ctrl_alu_decode
  import mc_control_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (opcode)
      OP_R: begin
        alu_op = '0;
        legal  = 1'b0;
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          case (funct3)
            F3_ADD:  alu_op = ALU_ADD;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SLT:  alu_op = ALU_SLT;
            F3_AND:  alu_op = ALU_AND;
            default: legal  = 1'b0;
          endcase
        end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
          alu_op = ALU_SUB;
          legal  = 1'b1;
        end
      end
      OP_I: begin
        case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_XOR:  alu_op = ALU_XOR;
          F3_SLT:  alu_op = ALU_SLT;
          F3_AND:  alu_op = ALU_AND;
          default: begin
            alu_op = '0;
            legal  = 1'b0;
          end
        endcase
      end
      OP_LOAD:  legal = funct3 inside {F3_D, F3_W, F3_H, F3_BU};
      OP_STORE: legal = funct3 inside {F3_D, F3_W, F3_H, F3_B};
      OP_BRANCH: begin
        alu_op = ALU_SUB;
`ifdef CTRL_BRANCH_EXT_EN
        legal = funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE};
`else
        legal = funct3 inside {F3_BEQ, F3_BNE};
`endif
      end
      OP_JAL, OP_JALR, OP_LUI, OP_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: Moore multicycle control FSM for the RV64 datapath.
//   clk    clock
//   reset  asynchronous, active-low
//   bus    mc_control_unit_if.master (instruction/ALU flags in, all
//          datapath control flags and halted out)
// Parameter HALT_ON_EXC: 1 parks in HALT after an exception, 0 refetches.
// Macro CTRL_BRANCH_EXT_EN (in ctrl_alu_decode): enables blt/bge.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter bit HALT_ON_EXC = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  mc_control_unit_if.master bus
);

  ctrl_state_e state, next_state;
  logic        branch_taken_q;
  logic        br_taken;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [3:0]  dec_op;
  logic        dec_legal;

  assign opcode = bus.instruction[6:0];
  assign funct3 = bus.instruction[14:12];
  assign funct7 = bus.instruction[31:25];

  ctrl_alu_decode u_dec (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_op (dec_op),
    .legal  (dec_legal)
  );

  always_comb begin
    case (funct3)
      F3_BNE:  br_taken = !bus.alu_equal;
      F3_BLT:  br_taken = bus.alu_less;
      F3_BGE:  br_taken = !bus.alu_less;
      default: br_taken = bus.alu_equal;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= FETCH;
      branch_taken_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == BR_CMP && dec_legal) branch_taken_q <= br_taken;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:   next_state = IR_LOAD;
      IR_LOAD: next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:              next_state = EXEC_R;
          OP_I:              next_state = EXEC_I;
          OP_LOAD, OP_STORE: next_state = dec_legal ? MEM_ADDR : EXCEPT;
          OP_BRANCH:         next_state = BR_CMP;
          OP_JAL:            next_state = JAL;
          OP_JALR:           next_state = JALR;
          OP_LUI:            next_state = LUI;
          OP_SYSTEM:         next_state = HALT;
          default:           next_state = EXCEPT;
        endcase
      end
      EXEC_R:    next_state = dec_legal ? ALU_WB : EXCEPT;
      EXEC_I:    next_state = ALU_WB;
      ALU_WB:    next_state = FETCH;
      MEM_ADDR:  next_state = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:    next_state = MEM_LATCH;
      MEM_LATCH: next_state = LOAD_WB;
      LOAD_WB:   next_state = FETCH;
      MEM_WR:    next_state = FETCH;
      BR_CMP:    next_state = dec_legal ? BR_TGT : EXCEPT;
      BR_TGT:    next_state = FETCH;
      JAL:       next_state = FETCH;
      JALR:      next_state = FETCH;
      LUI:       next_state = ALU_WB;
      EXCEPT:    next_state = HALT_ON_EXC ? HALT : FETCH;
      HALT:      next_state = HALT;
      default:   next_state = FETCH;
    endcase
  end

  always_comb begin
    bus.PCWriteState = 1'b0;
    bus.PCSource     = 1'b0;
    bus.ALUSrcA      = '0;
    bus.ALUSrcB      = '0;
    bus.ALUOp        = '0;
    bus.LoadAOut     = 1'b0;
    bus.LoadRegA     = 1'b0;
    bus.LoadRegB     = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.LoadMDR      = 1'b0;
    bus.MemToReg     = '0;
    bus.DMemOp       = 1'b0;
    bus.LoadSplice   = '0;
    bus.StoreSplice  = '0;
    bus.IMemRead     = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.IntCause     = 1'b0;
    bus.EPCWrite     = 1'b0;
    bus.CauseWrite   = 1'b0;
    bus.halted       = 1'b0;
    case (state)
      FETCH: bus.IMemRead = 1'b1;
      IR_LOAD: begin
        bus.IRWrite  = 1'b1;
        bus.ALUSrcB  = 2'b01;
        bus.ALUOp    = ALU_ADD;
        bus.LoadAOut = 1'b1;
      end
      DECODE: begin
        bus.LoadRegA = 1'b1;
        bus.LoadRegB = 1'b1;
        // Branches and jumps keep the old PC: BR_TGT/JAL need it for PC+imm.
        if (!(opcode inside {OP_BRANCH, OP_JAL, OP_JALR})) begin
          bus.PCWriteState = 1'b1;
          bus.PCSource     = 1'b1;
        end
      end
      EXEC_R: begin
        bus.ALUSrcA  = 2'b01;
        bus.ALUOp    = dec_op;
        // Suppressed on an illegal op so ALUOut still holds PC+4 for EPC.
        bus.LoadAOut = dec_legal;
      end
      EXEC_I: begin
        bus.ALUSrcA  = 2'b01;
        bus.ALUSrcB  = 2'b10;
        bus.ALUOp    = dec_op;
        bus.LoadAOut = 1'b1;
      end
      ALU_WB: bus.RegWrite = 1'b1;
      MEM_ADDR: begin
        bus.ALUSrcA  = 2'b01;
        bus.ALUSrcB  = 2'b10;
        bus.ALUOp    = ALU_ADD;
        bus.LoadAOut = 1'b1;
      end
      MEM_LATCH: bus.LoadMDR = 1'b1;
      LOAD_WB: begin
        bus.RegWrite   = 1'b1;
        bus.MemToReg   = 2'b01;
        bus.LoadSplice = load_splice(funct3);
      end
      MEM_WR: begin
        bus.DMemOp      = 1'b1;
        bus.StoreSplice = store_splice(funct3);
      end
      BR_CMP: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUOp   = ALU_SUB;
      end
      BR_TGT: begin
        bus.ALUSrcB      = 2'b10;
        bus.ALUOp        = ALU_ADD;
        bus.PCWriteState = 1'b1;
        bus.PCSource     = !branch_taken_q;
      end
      JAL, JALR: begin
        bus.RegWrite     = 1'b1;
        bus.ALUSrcA      = (state == JALR) ? 2'b01 : 2'b00;
        bus.ALUSrcB      = 2'b10;
        bus.ALUOp        = ALU_ADD;
        bus.PCWriteState = 1'b1;
      end
      LUI: begin
        bus.ALUSrcA  = 2'b10;
        bus.ALUSrcB  = 2'b10;
        bus.ALUOp    = ALU_ADD;
        bus.LoadAOut = 1'b1;
      end
      EXCEPT: begin
        bus.CauseWrite = 1'b1;
        bus.EPCWrite   = 1'b1;
      end
      HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Moore-style multicycle control FSM that drives every control flag of the 64-bit RISC-V multicycle datapath. It consumes that datapath's instruction_out and ALU flag outputs.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and handles illegal-opcode exceptions.
- Instruction and data memories both have a 1-cycle registered read.

Parameters:
- HALT_ON_EXC, 1, 1 = park in HALT after an exception; 0 = restart at FETCH.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low (asserted at 0)
- instruction  in  32  instruction register contents
- alu_zero, alu_equal, alu_greater, alu_less  in  1 each  ALU flags
- PCWriteState, PCSource  out  1 each  PC load enable / PC mux select (0 = alu_res, 1 = ALUOut)
- ALUSrcA, ALUSrcB  out  2 each  ALU operand mux selects
- ALUOp  out  4  ALU function
- LoadAOut, LoadRegA, LoadRegB, RegWrite, LoadMDR  out  1 each  register load enables
- MemToReg  out  2  register-file write mux (00 = ALUOut, 01 = memory data, 10 = PC)
- DMemOp  out  1  data-memory write
- LoadSplice, StoreSplice  out  2 each  access size (00 = d, 01 = w, 10 = h, 11 = b)
- IMemRead, IRWrite  out  1 each  instruction fetch controls
- IntCause, EPCWrite, CauseWrite  out  1 each  exception controls
- halted  out  1  high in HALT

Behaviour:
- Reset: state = FETCH, branch_taken_q = 0. Every output takes its FETCH value, i.e. all 0 except IMemRead = 1.
- Outputs decode from state only. Exception: PCSource in BR_TGT = !branch_taken_q, which is registered and therefore glitch-free.
- Any output not listed for a state is 0.
- FETCH: IMemRead. Next state IR_LOAD.
- IR_LOAD: IRWrite; ALUOut <= PC+4 (ALUSrcA = 00, ALUSrcB = 01, ADD, LoadAOut). Next state DECODE.
- DECODE: LoadRegA, LoadRegB. For opcodes other than branch, JAL and JALR: PC <= ALUOut (PCSource = 1, PCWriteState).
- DECODE dispatch by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 / 0100011 -> MEM_ADDR
  - 1100011 -> BR_CMP
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 1110011 -> HALT
  - anything else -> EXCEPT
- EXEC_R: A op B, LoadAOut.
  - Supported funct3/funct7: add 000/0000000, sub 000/0100000, xor 100, slt 010, and 111.
  - Unsupported combination: no load, go to EXCEPT.
  - Supported: next state ALU_WB.
- EXEC_I: A op imm (ALUSrcB = 10); addi, xori, slti, andi; LoadAOut. Next state ALU_WB.
- ALU_WB: RegWrite, MemToReg = 00. Next state FETCH.
- MEM_ADDR: ALUOut <= A+imm. Next state MEM_RD for a load, MEM_WR for a store.
- MEM_RD: address presented. Next state MEM_LATCH.
- MEM_LATCH: LoadMDR. Next state LOAD_WB.
- LOAD_WB: RegWrite, MemToReg = 01, LoadSplice from funct3 (ld 011 = 00, lw 010 = 01, lh 001 = 10, lbu 100 = 11). Next state FETCH.
- MEM_WR: DMemOp = 1 for exactly one cycle, StoreSplice from funct3 (sd 011, sw 010, sh 001, sb 000). Next state FETCH.
- Loads and stores with an illegal funct3 go to EXCEPT straight from DECODE.
- BR_CMP: ALU SUB of A and B.
  - branch_taken_q <= beq: alu_equal; bne: !alu_equal.
  - Other funct3 -> EXCEPT (see the optional feature).
  - Next state BR_TGT.
- BR_TGT: ALU computes PC+imm, PCWriteState = 1, PCSource = !branch_taken_q (not taken selects the PC+4 held in ALUOut). Next state FETCH.
- JAL: RegWrite, MemToReg = 00 (writes PC+4); same cycle PC <= PC+imm (ALUSrcA = 00, ALUSrcB = 10, PCSource = 0, PCWriteState). Next state FETCH.
- JALR: same as JAL but ALUSrcA = 01 (rs1). Next state FETCH.
- LUI: ALUOut <= 0+imm (ALUSrcA = 10). Next state ALU_WB.
- EXCEPT: IntCause = 0 (opcode cause), CauseWrite, EPCWrite (EPC = ALUOut = PC+4). Next state HALT if HALT_ON_EXC, else FETCH.
- HALT: all enables 0, halted = 1. Left only by reset.
- Cycle counts: R/I/LUI = 5, load = 7, store = 5, branch = 5, JAL/JALR = 4.
- Reset asserted mid-instruction: immediate return to FETCH with no partial writes. Enables drop asynchronously.

Optional Feature:
- CTRL_BRANCH_EXT_EN defined: BR_CMP also decodes blt 100 (taken = alu_less) and bge 101 (taken = !alu_less).
- Undefined: funct3 100/101 on a branch goes to EXCEPT.

Decomposition:
- Package operations: the ctrl_state_e enum, the ALUOp constants ALU_ADD = 0001, ALU_SUB = 0010, ALU_AND = 0011, ALU_XOR = 0100, ALU_SLT = 0101, and the splice-size constants.
- Package opcodes: opcode and funct3/funct7 constants.
- One sub-module, ctrl_alu_decode: combinational mapping of funct3/funct7/opcode to {ALUOp, legal}.

Test Plan:
- Reset low during MEM_WR -> DMemOp drops at once; after release, state FETCH and IMemRead = 1.
- add x3,x1,x2 (0x002081B3) -> states FETCH, IR_LOAD, DECODE, EXEC_R, ALU_WB; RegWrite for one cycle, MemToReg = 00, ALUOp = 0001.
- ld (funct3 011) -> 7 cycles; LoadMDR then RegWrite with LoadSplice = 00 and MemToReg = 01.
- beq with alu_equal = 1 -> BR_TGT with PCSource = 0; with alu_equal = 0 -> PCSource = 1; PCWriteState = 1 in both.
- Opcode 0x7F -> EXCEPT with CauseWrite = EPCWrite = 1 and IntCause = 0, then halted = 1 and stays high.
- blt without CTRL_BRANCH_EXT_EN -> EXCEPT; with it and alu_less = 1 -> branch taken.
